// File: rtl/fmt_pkg.sv
// Shared types and constants for the formater packet receiver: FSM state encoding,
// channel id type, legal packet lengths and the counter width.
package fmt_pkg;

  localparam int FMT_MAX_LEN = 32;
  localparam int FMT_CNT_W   = 6;

  localparam logic [31:0] LEN_4  = 32'd4;
  localparam logic [31:0] LEN_8  = 32'd8;
  localparam logic [31:0] LEN_16 = 32'd16;
  localparam logic [31:0] LEN_32 = 32'd32;

  typedef logic [1:0] fmt_chid_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GRANT,
    ST_WAIT_START,
    ST_RECV,
    ST_DRAIN
  } fmt_state_e;

  function automatic logic fmt_len_legal(input logic [31:0] len);
    return (len == LEN_4) || (len == LEN_8) || (len == LEN_16) || (len == LEN_32);
  endfunction

endpackage

// File: rtl/fmt_rx_buf.sv
// Single packet buffer: DEPTH x DW register array with one synchronous write port
// and one combinational read port.
module fmt_rx_buf #(
  parameter int DEPTH = 32,
  parameter int DW    = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];

  // NOTE: the array has no reset; the FSM never reads a slot it has not written.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fmt_pkt_receiver.sv
// Formater-bus packet receiver: grants a pending packet, buffers it, checks its length
// and replays it on a valid/ready stream. Optional macro FMT_RX_ERR_CNT_EN adds err_cnt_o.
module fmt_pkt_receiver
  import fmt_pkg::*;
#(
  parameter int MAX_LEN   = FMT_MAX_LEN,
  parameter int DW        = 8,
  parameter int START_TMO = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          fmt_req_i,
  output logic          fmt_grant_o,
  input  logic [1:0]    fmt_chid_i,
  input  logic [31:0]   fmt_length_i,
  input  logic          fmt_start_i,
  input  logic          fmt_vld_i,
  input  logic [DW-1:0] fmt_data_i,
  input  logic          fmt_end_i,
  output logic          rx_vld_o,
  input  logic          rx_rdy_i,
  output logic [DW-1:0] rx_data_o,
  output logic [1:0]    rx_chid_o,
  output logic          rx_sop_o,
  output logic          rx_eop_o,
  output logic          rx_err_o,
  output logic          busy_o
`ifdef FMT_RX_ERR_CNT_EN
  ,
  output logic [15:0]   err_cnt_o
`endif
);

  localparam int AW    = $clog2(MAX_LEN);
  localparam int TMO_W = $clog2(START_TMO + 1);
  localparam logic [FMT_CNT_W-1:0] MAX_CNT  = FMT_CNT_W'(MAX_LEN);
  localparam logic [TMO_W-1:0]     TMO_LAST = TMO_W'(START_TMO - 1);

  fmt_state_e           state_q, state_d;
  fmt_chid_t            chid_q, chid_d;
  logic [31:0]          len_q, len_d;
  logic [FMT_CNT_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [FMT_CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic                 err_q, err_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;

  logic                 buf_we;
  logic [AW-1:0]        buf_waddr;
  logic [DW-1:0]        buf_rdata;
  logic [FMT_CNT_W-1:0] wr_next;
  logic                 drain_last;
  logic                 eop_xfer;
  logic                 tmo_hit;

  assign drain_last = (rd_cnt_q == wr_cnt_q - 1'b1);

  fmt_rx_buf #(
    .DEPTH (MAX_LEN),
    .DW    (DW),
    .AW    (AW)
  ) u_buf (
    .clk_i   (clk_i),
    .we_i    (buf_we),
    .waddr_i (buf_waddr),
    .wdata_i (fmt_data_i),
    .raddr_i (rd_cnt_q[AW-1:0]),
    .rdata_o (buf_rdata)
  );

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    chid_d      = chid_q;
    len_d       = len_q;
    wr_cnt_d    = wr_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    err_d       = err_q;
    tmo_d       = tmo_q;
    buf_we      = 1'b0;
    buf_waddr   = wr_cnt_q[AW-1:0];
    wr_next     = wr_cnt_q;
    eop_xfer    = 1'b0;
    tmo_hit     = 1'b0;
    fmt_grant_o = 1'b0;
    rx_vld_o    = 1'b0;
    rx_data_o   = '0;
    rx_sop_o    = 1'b0;
    rx_eop_o    = 1'b0;
    rx_err_o    = 1'b0;
    busy_o      = (state_q != ST_IDLE);
    rx_chid_o   = chid_q;

    unique case (state_q)
      ST_IDLE: begin
        if (fmt_req_i) state_d = ST_GRANT;
      end

      ST_GRANT: begin
        fmt_grant_o = 1'b1;
        tmo_d       = '0;
        err_d       = 1'b0;
        wr_cnt_d    = '0;
        rd_cnt_d    = '0;
        state_d     = ST_WAIT_START;
      end

      ST_WAIT_START: begin
        if (fmt_start_i && fmt_vld_i) begin
          chid_d    = fmt_chid_i;
          len_d     = fmt_length_i;
          buf_we    = 1'b1;
          buf_waddr = '0;
          wr_cnt_d  = FMT_CNT_W'(1);
          err_d     = !fmt_len_legal(fmt_length_i);
          if (fmt_end_i) begin
            err_d   = err_d || (fmt_length_i != 32'd1);
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_RECV;
          end
        end else if (tmo_q == TMO_LAST) begin
          tmo_hit = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      ST_RECV: begin
        if (fmt_vld_i) begin
          // Beats beyond the buffer are dropped; a repeated start is treated as data.
          if (wr_cnt_q < MAX_CNT) begin
            buf_we  = 1'b1;
            wr_next = wr_cnt_q + 1'b1;
          end else begin
            err_d = 1'b1;
          end
          if (fmt_start_i) err_d = 1'b1;
          wr_cnt_d = wr_next;
          if (fmt_end_i) begin
            if ({{(32-FMT_CNT_W){1'b0}}, wr_next} != len_q) err_d = 1'b1;
            state_d = ST_DRAIN;
          end
        end
      end

      ST_DRAIN: begin
        rx_vld_o  = 1'b1;
        rx_data_o = buf_rdata;
        rx_sop_o  = (rd_cnt_q == '0);
        rx_eop_o  = drain_last;
        rx_err_o  = drain_last && err_q;
        if (rx_rdy_i) begin
          if (drain_last) begin
            eop_xfer = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            rd_cnt_d = rd_cnt_q + 1'b1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      chid_q   <= '0;
      len_q    <= '0;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      err_q    <= 1'b0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      chid_q   <= chid_d;
      len_q    <= len_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      err_q    <= err_d;
      tmo_q    <= tmo_d;
    end
  end

`ifdef FMT_RX_ERR_CNT_EN
  logic [15:0] err_cnt_q;

  // Counts errored packets and start timeouts, saturating at all-ones.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_cnt_q <= '0;
    end else if (((eop_xfer && err_q) || tmo_hit) && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign err_cnt_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_fmt_pkt_receiver.sv
// Directed self-checking bench for fmt_pkt_receiver; define FMT_RX_ERR_CNT_EN to
// also check the error counter.
module tb_fmt_pkt_receiver;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        fmt_req_i = 1'b0;
  logic        fmt_grant_o;
  logic [1:0]  fmt_chid_i = '0;
  logic [31:0] fmt_length_i = '0;
  logic        fmt_start_i = 1'b0;
  logic        fmt_vld_i = 1'b0;
  logic [7:0]  fmt_data_i = '0;
  logic        fmt_end_i = 1'b0;
  logic        rx_vld_o;
  logic        rx_rdy_i = 1'b1;
  logic [7:0]  rx_data_o;
  logic [1:0]  rx_chid_o;
  logic        rx_sop_o;
  logic        rx_eop_o;
  logic        rx_err_o;
  logic        busy_o;
`ifdef FMT_RX_ERR_CNT_EN
  logic [15:0] err_cnt_o;
`endif

  int total = 0;
  int bad = 0;
  int grant_cnt = 0;

  always #5 clk = ~clk;

  fmt_pkt_receiver dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .fmt_req_i    (fmt_req_i),
    .fmt_grant_o  (fmt_grant_o),
    .fmt_chid_i   (fmt_chid_i),
    .fmt_length_i (fmt_length_i),
    .fmt_start_i  (fmt_start_i),
    .fmt_vld_i    (fmt_vld_i),
    .fmt_data_i   (fmt_data_i),
    .fmt_end_i    (fmt_end_i),
    .rx_vld_o     (rx_vld_o),
    .rx_rdy_i     (rx_rdy_i),
    .rx_data_o    (rx_data_o),
    .rx_chid_o    (rx_chid_o),
    .rx_sop_o     (rx_sop_o),
    .rx_eop_o     (rx_eop_o),
    .rx_err_o     (rx_err_o),
    .busy_o       (busy_o)
`ifdef FMT_RX_ERR_CNT_EN
    ,
    .err_cnt_o    (err_cnt_o)
`endif
  );

  always @(negedge clk) if (fmt_grant_o) grant_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raises req, waits for the grant pulse, and returns with the DUT in WAIT_START.
  task automatic do_grant(input string tag, input bit keep_req);
    bit got = 1'b0;
    fmt_req_i = 1'b1;
    for (int c = 0; c < 8 && !got; c++) begin
      tick();
      if (fmt_grant_o) got = 1'b1;
    end
    check({tag, "_grant"}, {31'd0, got}, 32'd1);
    if (!keep_req) fmt_req_i = 1'b0;
    tick();
    check({tag, "_grant_pulse"}, {31'd0, fmt_grant_o}, 32'd0);
  endtask

  // Drives n beats with data base+i; start on beat 0, end on the last beat if with_end.
  task automatic send(input logic [1:0] chid, input logic [31:0] len, input int n,
                      input logic [7:0] base, input bit with_end);
    for (int i = 0; i < n; i++) begin
      fmt_vld_i    = 1'b1;
      fmt_start_i  = (i == 0);
      fmt_end_i    = with_end && (i == n - 1);
      fmt_chid_i   = chid;
      fmt_length_i = len;
      fmt_data_i   = base + 8'(i);
      tick();
    end
    fmt_vld_i   = 1'b0;
    fmt_start_i = 1'b0;
    fmt_end_i   = 1'b0;
    fmt_data_i  = '0;
  endtask

  // Collects the drained packet, checking every presented beat against the expectation.
  task automatic drain(input string tag, input int n, input logic [7:0] base,
                       input bit exp_err, input logic [1:0] exp_chid, input bit toggle);
    int k = 0;
    bit done = 1'b0;
    for (int c = 0; c < 4 * n + 10 && !done; c++) begin
      rx_rdy_i = toggle ? (c % 2 == 0) : 1'b1;
      if (rx_vld_o) begin
        check({tag, "_data"}, {24'd0, rx_data_o}, {24'd0, base + 8'(k)});
        check({tag, "_sop"}, {31'd0, rx_sop_o}, {31'd0, (k == 0)});
        check({tag, "_eop"}, {31'd0, rx_eop_o}, {31'd0, (k == n - 1)});
        check({tag, "_chid"}, {30'd0, rx_chid_o}, {30'd0, exp_chid});
        if (rx_rdy_i) begin
          if (rx_eop_o) begin
            check({tag, "_err"}, {31'd0, rx_err_o}, {31'd0, exp_err});
            done = 1'b1;
          end
          k++;
        end
      end
      if (!done) tick();
    end
    check({tag, "_beats"}, k, n);
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    rx_rdy_i = 1'b1;
  endtask

  initial begin
    int g0;
    bit saw_vld;

    // Reset state
    tick();
    tick();
    check("rst_grant", {31'd0, fmt_grant_o}, 32'd0);
    check("rst_vld", {31'd0, rx_vld_o}, 32'd0);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_chid", {30'd0, rx_chid_o}, 32'd0);
    check("rst_sop_eop_err", {29'd0, rx_sop_o, rx_eop_o, rx_err_o}, 32'd0);
`ifdef FMT_RX_ERR_CNT_EN
    check("rst_errcnt", {16'd0, err_cnt_o}, 32'd0);
`endif
    rst_i = 1'b0;
    tick();

    // Basic 8-byte packet, chid 2, single grant pulse
    g0 = grant_cnt;
    do_grant("p8", 1'b0);
    check("p8_busy", {31'd0, busy_o}, 32'd1);
    send(2'd2, 32'd8, 8, 8'h10, 1'b1);
    check("p8_latency", {31'd0, rx_vld_o}, 32'd1);
    drain("p8", 8, 8'h10, 1'b0, 2'd2, 1'b0);
    check("p8_grants", grant_cnt - g0, 32'd1);
    tick();
    check("p8_idle", {31'd0, busy_o}, 32'd0);

    // 4-byte packet with ready toggling; outputs held while ready is low
    do_grant("p4", 1'b0);
    send(2'd1, 32'd4, 4, 8'hA0, 1'b1);
    drain("p4t", 4, 8'hA0, 1'b0, 2'd1, 1'b1);
    tick();

    // len=16 but end on beat 12 -> length error
    do_grant("p12", 1'b0);
    send(2'd3, 32'd16, 12, 8'h40, 1'b1);
    drain("p12", 12, 8'h40, 1'b1, 2'd3, 1'b0);
    tick();
`ifdef FMT_RX_ERR_CNT_EN
    check("p12_errcnt", {16'd0, err_cnt_o}, 32'd1);
`endif

    // Start timeout: 16 cycles in WAIT_START, then IDLE, no output, no retry
    g0 = grant_cnt;
    do_grant("tmo", 1'b0);
    saw_vld = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      saw_vld |= rx_vld_o;
    end
    check("tmo_still_waiting", {31'd0, busy_o}, 32'd1);
    tick();
    check("tmo_idle", {31'd0, busy_o}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      saw_vld |= rx_vld_o;
    end
    check("tmo_no_vld", {31'd0, saw_vld}, 32'd0);
    check("tmo_no_retry", grant_cnt - g0, 32'd1);
`ifdef FMT_RX_ERR_CNT_EN
    check("tmo_errcnt", {16'd0, err_cnt_o}, 32'd2);
`endif

    // New grant after timeout; single-beat packet gives sop&eop with length error
    do_grant("p1", 1'b0);
    send(2'd1, 32'd4, 1, 8'h77, 1'b1);
    check("p1_sop_eop", {30'd0, rx_sop_o, rx_eop_o}, 32'd3);
    drain("p1", 1, 8'h77, 1'b1, 2'd1, 1'b0);
    tick();
`ifdef FMT_RX_ERR_CNT_EN
    check("p1_errcnt", {16'd0, err_cnt_o}, 32'd3);
`endif

    // Reset during RECV on beat 5 of 32 abandons the packet
    do_grant("rst", 1'b0);
    send(2'd2, 32'd32, 5, 8'h00, 1'b0);
    fmt_vld_i  = 1'b1;
    fmt_data_i = 8'h05;
    rst_i      = 1'b1;
    tick();
    check("midrst_outs", {24'd0, fmt_grant_o, rx_vld_o, rx_sop_o, rx_eop_o, rx_err_o,
                          busy_o, rx_chid_o}, 32'd0);
    check("midrst_data", {24'd0, rx_data_o}, 32'd0);
`ifdef FMT_RX_ERR_CNT_EN
    check("midrst_errcnt", {16'd0, err_cnt_o}, 32'd0);
`endif
    rst_i      = 1'b0;
    fmt_vld_i  = 1'b0;
    fmt_data_i = '0;
    saw_vld    = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      saw_vld |= rx_vld_o | busy_o;
    end
    check("midrst_no_drain", {31'd0, saw_vld}, 32'd0);

    // Req held through DRAIN: no grant until eop accepted, then grant 2 cycles later
    do_grant("hold", 1'b1);
    send(2'd1, 32'd8, 8, 8'h80, 1'b1);
    g0 = grant_cnt;
    drain("hold", 8, 8'h80, 1'b0, 2'd1, 1'b0);
    check("hold_no_grant", grant_cnt - g0, 32'd0);
    tick();
    check("hold_gap", {30'd0, fmt_grant_o, busy_o}, 32'd0);
    tick();
    check("hold_regrant", {31'd0, fmt_grant_o}, 32'd1);
    fmt_req_i = 1'b0;
    tick();

    // Full 32-byte packet at the buffer limit, no error
    send(2'd3, 32'd32, 32, 8'hC0, 1'b1);
    drain("p32", 32, 8'hC0, 1'b0, 2'd3, 1'b0);
    tick();

    // 34 beats with len=32: extra beats dropped, error flagged
    do_grant("ovf", 1'b0);
    send(2'd0, 32'd32, 34, 8'h20, 1'b1);
    drain("ovf", 32, 8'h20, 1'b1, 2'd0, 1'b0);
    tick();
`ifdef FMT_RX_ERR_CNT_EN
    check("ovf_errcnt", {16'd0, err_cnt_o}, 32'd1);
`endif
    check("end_idle", {31'd0, busy_o}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
